dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Two-requester arbiter/sequencer in front of the byte-addressed, 32-bit-word data memory.
//  Port 0 = core load/store stage, port 1 = debug/DMA loader.
//  Grants one request at a time, drives the memory's MemWrite/MemRead strobes for exactly one cycle,
//  captures the registered read data and returns a one-cycle response to the winner.
//  Out-of-range accesses are blocked and flagged.
// PARAMETERS
//  ADDR_W     32    address width of requester ports and dmem_address
//  DATA_W     32    data width (one memory word)
//  MEM_BYTES  2048  memory size in bytes; valid when addr+3 <= MEM_BYTES-1
// PORTS
//  clk            in   1       single clock, all logic on rising edge
//  rst            in   1       synchronous reset, active-high
//  p0_req         in   1       port0 request valid, held until p0_ready
//  p0_we          in   1       port0 1=write 0=read
//  p0_addr        in   ADDR_W  port0 byte address
//  p0_wdata       in   DATA_W  port0 write data
//  p0_ready       out  1       port0 request accepted this cycle
//  p0_rsp_valid   out  1       port0 response pulse (read data or write done)
//  p0_rdata       out  DATA_W  port0 read data, valid with p0_rsp_valid
//  p0_err         out  1       port0 out-of-range flag, valid with p0_rsp_valid
//  p1_*           -    -       identical set for port1
//  MemWrite       out  1       memory write strobe
//  MemRead        out  1       memory read strobe
//  dmem_address   out  ADDR_W  memory byte address
//  write_data_mem out  DATA_W  memory write data
//  read_data      in   DATA_W  memory read data; valid the cycle after MemRead
//  busy           out  1       state != IDLE
// BEHAVIOUR
//  - FSM: IDLE -> ISSUE -> RESP -> IDLE; strict sequence, one transaction per 3 cycles.
//  - IDLE:
//    - pi_ready is combinational and asserts only for the winner in the cycle a request is present.
//    - On accept, register we, addr, wdata, port id and range error err = (addr > MEM_BYTES-4); go to ISSUE.
//    - While not IDLE, both pi_ready = 0.
//  - ISSUE (1 cycle):
//    - dmem_address and write_data_mem are driven from the captured regs.
//    - If no error: MemWrite = we, MemRead = !we.
//    - If error: both strobes = 0.
//    - Go to RESP.
//  - RESP (1 cycle):
//    - Winner's pi_rsp_valid = 1 and pi_err = err.
//    - pi_rdata = read_data for an error-free read, else 0.
//    - Other port's response outputs stay 0. Go to IDLE.
//  - Latency: accept at T, strobe at T+1, rsp_valid at T+2.
//    - The next accept is possible at T+3, because RESP returns to IDLE at T+3.
//  - Strobes are never both high. Strobes are high only in ISSUE, for exactly one cycle per transaction.
//  - A requester may drop pi_req before ready; nothing is issued. Request fields are sampled only in the accept cycle.
//  - Simultaneous p0_req and p1_req: the winner is set by the arbitration policy (see CONFIGURATION).
//  - Boundary: addr = MEM_BYTES-4 is valid; MEM_BYTES-3 and above, including 32-bit wrap, give err.
//  - Reset, in any state:
//    - FSM goes to IDLE.
//    - All outputs become 0: ready, rsp_valid, rdata, err, strobes, dmem_address, write_data_mem, busy.
//    - Round-robin pointer resets to "port0 next".
//    - An in-flight transaction is discarded with no response; the requester must re-request.
//  - dmem_address and write_data_mem hold their last values outside ISSUE (0 after reset).
// CONFIGURATION
//  DMEM_ARB_RR_EN defined:
//    - Round-robin. On a tie the port not granted last wins.
//    - The pointer updates on every accept, including error accepts.
//  DMEM_ARB_RR_EN undefined:
//    - Fixed priority, port0 always wins a tie.
//    - Port1 can starve under continuous port0 traffic; this is accepted for the core-first build.
// TESTING
//  1. p0 write addr=0x10 wdata=0xDEADBEEF:
//     - p0_ready at T; MemWrite=1 with dmem_address=0x10 at T+1; p0_rsp_valid=1, err=0 at T+2.
//  2. p0 read addr=0x10 after test 1:
//     - MemRead at T+1; p0_rsp_valid at T+2 with p0_rdata=0xDEADBEEF.
//  3. p0 and p1 read requests held high for 4 accepts:
//     - RR build: grants p0,p1,p0,p1 at cycles 0,3,6,9.
//     - Fixed build: p0 every 3 cycles, p1 never.
//  4. p1 read addr=0x7FC -> valid, strobe issued.
//     p1 read addr=0x7FD -> no strobe, p1_rsp_valid=1 with p1_err=1 and p1_rdata=0.
//  5. rst=1 during ISSUE of a p0 write:
//     - Next cycle all outputs = 0 and state is IDLE; no rsp_valid appears.
//     - A later read of that address returns the pre-write content.
//  6. p1_req pulsed high then low while busy (never sees ready):
//     - No strobe and no p1_rsp_valid.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// dmem_port_arbiter_if: request/response bundle for one data-memory requester port
interface dmem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              req;
   logic              we;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic              ready;
   logic              rsp_valid;
   logic [DATA_W-1:0] rdata;
   logic              err;
   modport master (output req, we, addr, wdata, input ready, rsp_valid, rdata, err);
   modport slave  (input req, we, addr, wdata, output ready, rsp_valid, rdata, err);
endinterface

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: two-port arbiter/sequencer for the data memory; DMEM_ARB_RR_EN selects round-robin instead of fixed port0 priority
module dmem_port_arbiter #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MEM_BYTES = 2048
) (
   input  logic                clk,
   input  logic                rst,
   dmem_port_arbiter_if.slave  p0,
   dmem_port_arbiter_if.slave  p1,
   output logic                MemWrite,
   output logic                MemRead,
   output logic [ADDR_W-1:0]   dmem_address,
   output logic [DATA_W-1:0]   write_data_mem,
   input  logic [DATA_W-1:0]   read_data,
   output logic                busy
);
   localparam logic [ADDR_W-1:0] last_word = ADDR_W'(MEM_BYTES - 4);
   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
   state_t            state;
   logic              we_q, err_q, port_q, mw_q, mr_q, rsp0, rsp1, err0, err1;
   logic              sel, acc, sel_we, sel_err;
   logic [ADDR_W-1:0] sel_addr;
`ifdef DMEM_ARB_RR_EN
   logic              rr_p1;
   assign sel = p1.req & (~p0.req | rr_p1);
`else
   assign sel = p1.req & ~p0.req;
`endif
   assign acc      = (state == IDLE) & (p0.req | p1.req) & ~rst;
   assign sel_we   = sel ? p1.we : p0.we;
   assign sel_addr = sel ? p1.addr : p0.addr;
   assign sel_err  = sel_addr > last_word;
   assign p0.ready = acc & ~sel;
   assign p1.ready = acc & sel;
   // a reset landing in ISSUE must keep the pending strobe away from the memory
   assign MemWrite = mw_q & ~rst;
   assign MemRead  = mr_q & ~rst;
   assign busy     = state != IDLE;
   assign p0.rsp_valid = rsp0;
   assign p1.rsp_valid = rsp1;
   assign p0.err   = err0;
   assign p1.err   = err1;
   assign p0.rdata = (rsp0 & ~we_q & ~err_q) ? read_data : '0;
   assign p1.rdata = (rsp1 & ~we_q & ~err_q) ? read_data : '0;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         {we_q, err_q, port_q, mw_q, mr_q, rsp0, rsp1, err0, err1} <= '0;
         dmem_address   <= '0;
         write_data_mem <= '0;
`ifdef DMEM_ARB_RR_EN
         rr_p1 <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: if (acc) begin
               state          <= ISSUE;
               we_q           <= sel_we;
               err_q          <= sel_err;
               port_q         <= sel;
               mw_q           <= sel_we & ~sel_err;
               mr_q           <= ~sel_we & ~sel_err;
               dmem_address   <= sel_addr;
               write_data_mem <= sel ? p1.wdata : p0.wdata;
`ifdef DMEM_ARB_RR_EN
               rr_p1          <= ~sel;
`endif
            end
            ISSUE: begin
               state <= RESP;
               mw_q  <= 1'b0;
               mr_q  <= 1'b0;
               rsp0  <= ~port_q;
               rsp1  <= port_q;
               err0  <= ~port_q & err_q;
               err1  <= port_q & err_q;
            end
            default: begin
               state <= IDLE;
               {rsp0, rsp1, err0, err1} <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb_dmem_port_arbiter: randomized bench for dmem_port_arbiter against a transaction-level model; honours DMEM_ARB_RR_EN
module tb_dmem_port_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        MemWrite, MemRead, busy;
   logic [31:0] dmem_address, write_data_mem;
   logic [31:0] read_data = '0;
   logic [31:0] mem     [512];
   logic [31:0] ref_mem [512];
   int          vectors = 0, miscompares = 0, cyc = 0, t_acc = 0, ph = 0, p1_rsp_seen = 0;
   logic        mon_en = 1'b0, have = 1'b0, rr_p1 = 1'b0;
   logic        m_port, m_we, m_err, w1, acc, rsp;
   logic [31:0] m_addr, m_wdata, erd;
   logic [31:0] last_addr = '0, last_wdata = '0;
   int          grant_port[$], grant_cyc[$];
   always #5 clk = ~clk;
   dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) p0_if ();
   dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) p1_if ();
   dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_BYTES(2048)) dut (
      .clk(clk), .rst(rst), .p0(p0_if), .p1(p1_if),
      .MemWrite(MemWrite), .MemRead(MemRead), .dmem_address(dmem_address),
      .write_data_mem(write_data_mem), .read_data(read_data), .busy(busy)
   );
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (MemWrite) mem[dmem_address[10:2]] <= write_data_mem;
      if (MemRead) read_data <= mem[dmem_address[10:2]];
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask
   // transaction-level model: one request in flight, strobe one cycle after accept, response two cycles after
   always @(negedge clk) if (mon_en) begin
      if (have && cyc - t_acc >= 3) have = 1'b0;
      ph = have ? cyc - t_acc : 0;
      if (ph == 1) begin
         last_addr  = m_addr;
         last_wdata = m_wdata;
      end
`ifdef DMEM_ARB_RR_EN
      w1 = p1_if.req && (!p0_if.req || rr_p1);
`else
      w1 = p1_if.req && !p0_if.req;
`endif
      acc = !have && (p0_if.req || p1_if.req) && !rst;
      rsp = ph == 2;
      erd = (rsp && !m_we && !m_err) ? ref_mem[m_addr[10:2]] : 32'h0;
      check("p0_ready", 32'(p0_if.ready), 32'(acc && !w1));
      check("p1_ready", 32'(p1_if.ready), 32'(acc && w1));
      check("MemWrite", 32'(MemWrite), 32'(ph == 1 && m_we && !m_err && !rst));
      check("MemRead", 32'(MemRead), 32'(ph == 1 && !m_we && !m_err && !rst));
      check("dmem_address", dmem_address, last_addr);
      check("write_data_mem", write_data_mem, last_wdata);
      check("busy", 32'(busy), 32'(ph == 1 || ph == 2));
      check("p0_rsp_valid", 32'(p0_if.rsp_valid), 32'(rsp && !m_port));
      check("p1_rsp_valid", 32'(p1_if.rsp_valid), 32'(rsp && m_port));
      check("p0_err", 32'(p0_if.err), 32'(rsp && !m_port && m_err));
      check("p1_err", 32'(p1_if.err), 32'(rsp && m_port && m_err));
      check("p0_rdata", p0_if.rdata, m_port ? 32'h0 : erd);
      check("p1_rdata", p1_if.rdata, m_port ? erd : 32'h0);
      if (p1_if.rsp_valid) p1_rsp_seen++;
      if (ph == 1 && !rst && m_we && !m_err) ref_mem[m_addr[10:2]] = m_wdata;
      if (acc) begin
         have    = 1'b1;
         t_acc   = cyc;
         m_port  = w1;
         m_we    = w1 ? p1_if.we : p0_if.we;
         m_addr  = w1 ? p1_if.addr : p0_if.addr;
         m_wdata = w1 ? p1_if.wdata : p0_if.wdata;
         m_err   = m_addr > 32'd2044;
         rr_p1   = !w1;
         grant_port.push_back(int'(w1));
         grant_cyc.push_back(cyc);
      end
      if (rst) begin
         have       = 1'b0;
         last_addr  = '0;
         last_wdata = '0;
         rr_p1      = 1'b0;
      end
   end
   task automatic drive(input logic port, input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata);
      if (port) begin
         p1_if.req = req; p1_if.we = we; p1_if.addr = addr; p1_if.wdata = wdata;
      end else begin
         p0_if.req = req; p0_if.we = we; p0_if.addr = addr; p0_if.wdata = wdata;
      end
   endtask
   task automatic wait_ready(input logic port);
      logic got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = port ? p1_if.ready : p0_if.ready;
      end
      check("accept_within_budget", 32'(got), 32'd1);
   endtask
   task automatic xact(input logic port, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err);
      logic got = 1'b0;
      rdata = '0;
      err   = 1'b0;
      @(posedge clk); #1;
      drive(port, 1'b1, we, addr, wdata);
      wait_ready(port);
      @(posedge clk); #1;
      drive(port, 1'b0, 1'b0, '0, '0);
      for (int i = 0; i < 5 && !got; i++) begin
         @(negedge clk);
         got = port ? p1_if.rsp_valid : p0_if.rsp_valid;
         rdata = port ? p1_if.rdata : p0_if.rdata;
         err   = port ? p1_if.err : p0_if.err;
      end
      check("response_within_budget", 32'(got), 32'd1);
   endtask
   function automatic logic [31:0] pick_addr();
      int k = $urandom_range(0, 9);
      return k == 0 ? 32'h7FC : k == 1 ? 32'h7FD + $urandom_range(0, 3) :
             k == 2 ? 32'hFFFF_FFFC + $urandom_range(0, 3) : 32'($urandom_range(0, 15)) << 2;
   endfunction
   initial begin
      logic [31:0] rd;
      logic        er, a0, a1;
      int          seen;
      for (int i = 0; i < 512; i++) begin
         mem[i]     = 32'h5A00_0000 ^ (i * 32'h0001_0003);
         ref_mem[i] = 32'h5A00_0000 ^ (i * 32'h0001_0003);
      end
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      repeat (3) @(posedge clk);
      #1 mon_en = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      xact(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, rd, er);
      check("t1_err", 32'(er), 32'd0);
      xact(1'b0, 1'b0, 32'h10, 32'h0, rd, er);
      check("t2_rdata", rd, 32'hDEAD_BEEF);
      xact(1'b1, 1'b0, 32'h7FC, 32'h0, rd, er);
      check("t4_last_word_err", 32'(er), 32'd0);
      xact(1'b1, 1'b0, 32'h7FD, 32'h0, rd, er);
      check("t4_past_end_err", 32'(er), 32'd1);
      check("t4_past_end_rdata", rd, 32'h0);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      grant_port.delete();
      grant_cyc.delete();
      drive(1'b0, 1'b1, 1'b0, 32'h20, '0);
      drive(1'b1, 1'b1, 1'b0, 32'h24, '0);
      repeat (10) @(posedge clk);
      #1;
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      repeat (3) @(posedge clk);
      check("t3_grant_count", 32'(grant_port.size()), 32'd4);
      for (int i = 0; i < grant_port.size() && i < 4; i++) begin
`ifdef DMEM_ARB_RR_EN
         check("t3_grant_port", 32'(grant_port[i]), 32'(i % 2));
`else
         check("t3_grant_port", 32'(grant_port[i]), 32'd0);
`endif
         check("t3_grant_spacing", 32'(grant_cyc[i] - grant_cyc[0]), 32'(3 * i));
      end
      xact(1'b0, 1'b1, 32'h30, 32'h1111_1111, rd, er);
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 1'b1, 32'h30, 32'h2222_2222);
      wait_ready(1'b0);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      xact(1'b0, 1'b0, 32'h30, 32'h0, rd, er);
      check("t5_prewrite_data", rd, 32'h1111_1111);
      @(posedge clk); #1;
      drive(1'b0, 1'b1, 1'b0, 32'h40, '0);
      wait_ready(1'b0);
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      drive(1'b1, 1'b1, 1'b0, 32'h44, '0);
      seen = p1_rsp_seen;
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      repeat (6) @(posedge clk);
      check("t6_dropped_p1_rsp", 32'(p1_rsp_seen - seen), 32'd0);
      for (int n = 0; n < 1500; n++) begin
         @(negedge clk);
         a0 = p0_if.ready;
         a1 = p1_if.ready;
         @(posedge clk); #1;
         rst = $urandom_range(0, 199) == 0;
         if (!p0_if.req || a0 || $urandom_range(0, 9) == 0)
            drive(1'b0, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), pick_addr(), $urandom);
         if (!p1_if.req || a1 || $urandom_range(0, 9) == 0)
            drive(1'b1, $urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)), pick_addr(), $urandom);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      repeat (4) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
